fetch_prefetch_buffer: RTL
==========================

Name: fetch_prefetch_buffer

Overview:
Instruction-fetch front end sitting directly upstream of the single-cycle core's instruction path. It owns the fetch PC and issues in-order word requests to a variable-latency instruction memory. It buffers up to DEPTH returned instructions with their PCs and presents them to the core through a valid/ready handshake. A redirect flushes all buffered and in-flight fetches and restarts fetch at a new PC.

Parameters:
DEPTH, 4, entries in the fetch buffer and maximum requests in flight; power of two, 2..16
RESET_PC, 32'h0000_0000, fetch PC loaded on reset

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
req_valid  output  1  fetch request to instruction memory
req_ready  input  1  memory accepts request this cycle
req_addr  output  32  word address of request, bits [1:0] always 0
resp_valid  input  1  one response, in request order, never stalled
resp_data  input  32  returned instruction word
redirect_valid  input  1  flush and restart fetch (branch/jump target)
redirect_pc  input  32  new fetch PC; bits [1:0] ignored and forced to 0
instr_valid  output  1  head entry holds a returned instruction
instr_ready  input  1  core consumes head entry
instr_data  output  32  head instruction word
instr_pc  output  32  PC of head instruction

Behaviour:
- Reset (rst=0, async): fetch_pc=RESET_PC; all pointers, entry-valid/filled bits, discard_cnt=0; req_valid=0, instr_valid=0, instr_data=0, instr_pc=0. Reset asserted mid-operation abandons all in-flight work; responses arriving while rst=0 are ignored.
- Storage: circular array of DEPTH entries {pc, data, filled}; three pointers: alloc_ptr, fill_ptr, rd_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH; a separate count (0..DEPTH) resolves full vs empty.
- Credit: req_valid = (allocated entries + discard_cnt < DEPTH) and not redirect_valid. req_addr = fetch_pc.
- Request accept (req_valid & req_ready): entry[alloc_ptr].pc <= fetch_pc, filled<=0, alloc_ptr++, fetch_pc <= fetch_pc+4 (wraps at 2^32).
- Response (resp_valid): if discard_cnt>0, discard_cnt-- and data dropped; else entry[fill_ptr].data<=resp_data, filled<=1, fill_ptr++. A response with nothing outstanding is a protocol error; state is unchanged.
- Output: instr_valid = count>0 & entry[rd_ptr].filled; instr_data/instr_pc driven from the head entry, held stable while instr_valid & !instr_ready. Pop on instr_valid & instr_ready: rd_ptr++, count--.
- Minimum latency: request accepted in cycle N, response in N+1 makes instr_valid high in N+2.
- Same cycle accept + response + pop are all legal and applied together. count = count + accept - pop.
- Redirect (highest priority):
  - all entries invalidated; pointers and count cleared; fetch_pc <= {redirect_pc[31:2],2'b00}.
  - discard_cnt <= discard_cnt + (allocated unfilled entries) - (resp_valid ? 1 : 0).
  - no pop takes effect and no request is issued in the redirect cycle.
  - instr_valid is low the following cycle.
- Back-to-back redirects accumulate discard_cnt correctly. discard_cnt never exceeds DEPTH.
- Full: allocated + discard_cnt = DEPTH forces req_valid low until a pop or a discarded response frees credit.

Test Plan:
- Reset release, req_ready=1, memory latency 1, instr_ready=1 -> req_addr sequence 0,4,8,12…; instr_pc 0,4,8 with matching data, one instruction per cycle after 2-cycle start-up.
- instr_ready=0, DEPTH=4, latency 1 -> exactly 4 requests accepted (addr 0..12), req_valid then low. Head holds pc=0 stable. Raising instr_ready drains pcs 0,4,8,12 in order.
- 3 requests outstanding (latency 5), redirect_pc=32'h100 -> discard_cnt=3, 3 late responses dropped. First delivered instruction has instr_pc=0x100. Total in flight never exceeds 4.
- Redirect in same cycle as a resp_valid and an instr_ready pop -> response dropped, no pop, discard_cnt = outstanding-1. Next cycle instr_valid=0, req_addr=redirect target.
- redirect_pc=32'h0000_0203 -> req_addr=32'h0000_0200. Fetch near 32'hFFFF_FFFC wraps to 32'h0000_0000.
- rst pulsed low asynchronously mid-stream with 2 buffered and 2 in flight -> outputs zero immediately. After release, req_addr=RESET_PC, no stale instruction is delivered.

Source files
------------

// File: rtl/fetch_prefetch_buffer.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order word requests to a
// variable-latency instruction memory, buffers returned words with their PCs and hands
// them to the core over valid/ready. A redirect flushes everything and restarts fetch.
module fetch_prefetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        req_valid_o,
    input  logic        req_ready_i,
    output logic [31:0] req_addr_o,
    input  logic        resp_valid_i,
    input  logic [31:0] resp_data_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_data_o,
    output logic [31:0] instr_pc_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW:0] DepthVal = (CntW + 1)'(DEPTH);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [PtrW-1:0]  alloc_ptr_q, alloc_ptr_d;
    logic [PtrW-1:0]  fill_ptr_q, fill_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;       // allocated entries (filled or not)
    logic [CntW-1:0]  out_q, out_d;           // allocated entries still awaiting data
    logic [CntW-1:0]  discard_q, discard_d;   // in-flight responses to throw away
    logic [DEPTH-1:0] filled_q, filled_d;

    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] data_mem [DEPTH];

    logic [CntW:0] used;
    logic          accept;
    logic          resp_drop;
    logic          resp_fill;
    logic          head_valid;
    logic          pop;
    logic          unused_redirect_lo;

    assign unused_redirect_lo = ^redirect_pc_i[1:0];

    // Credit, handshakes and head-of-buffer outputs.
    always_comb begin
        used        = {1'b0, count_q} + {1'b0, discard_q};
        // Reset gating keeps the request line quiet while rst_ni is held low.
        req_valid_o = (used < DepthVal) && !redirect_valid_i && rst_ni;
        req_addr_o  = fetch_pc_q;
        accept      = req_valid_o && req_ready_i;
        resp_drop   = resp_valid_i && (discard_q != '0);
        // A response with nothing outstanding is ignored.
        resp_fill   = resp_valid_i && (discard_q == '0) && (out_q != '0);
        head_valid  = (count_q != '0) && filled_q[rd_ptr_q];
        pop         = head_valid && instr_ready_i && !redirect_valid_i;
        instr_valid_o = head_valid;
        instr_data_o  = head_valid ? data_mem[rd_ptr_q] : 32'h0;
        instr_pc_o    = head_valid ? pc_mem[rd_ptr_q] : 32'h0;
    end

    // Next-state: redirect overrides accept/fill/pop for the whole cycle.
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        alloc_ptr_d = alloc_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_d       = out_q;
        discard_d   = discard_q;
        filled_d    = filled_q;
        if (redirect_valid_i) begin
            fetch_pc_d  = {redirect_pc_i[31:2], 2'b00};
            alloc_ptr_d = '0;
            fill_ptr_d  = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            out_d       = '0;
            filled_d    = '0;
            // Every unfilled entry becomes a discard; a response this cycle retires one.
            discard_d   = discard_q + out_q - CntW'(resp_drop || resp_fill);
        end else begin
            if (accept) begin
                fetch_pc_d            = fetch_pc_q + 32'd4;
                alloc_ptr_d           = alloc_ptr_q + 1'b1;
                filled_d[alloc_ptr_q] = 1'b0;
            end
            if (resp_drop) begin
                discard_d = discard_q - 1'b1;
            end
            if (resp_fill) begin
                filled_d[fill_ptr_q] = 1'b1;
                fill_ptr_d           = fill_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CntW'(accept) - CntW'(pop);
            out_d   = out_q + CntW'(accept) - CntW'(resp_fill);
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc_q  <= RESET_PC;
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_q       <= '0;
            discard_q   <= '0;
            filled_q    <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_q       <= out_d;
            discard_q   <= discard_d;
            filled_q    <= filled_d;
        end
    end

    // Entry payload storage; contents are only observed when the filled bit is set.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            pc_mem[alloc_ptr_q] <= fetch_pc_q;
        end
        if (resp_fill && !redirect_valid_i) begin
            data_mem[fill_ptr_q] <= resp_data_i;
        end
    end

endmodule
